// File: rtl/gradient_ci_requester.sv
// -----------------------------------------------------------------------------
// gradient_ci_requester
//
// Initiator side of the custom-instruction (CI) interface for the gradient CI.
// Each packed 4-pixel neighbourhood {down,up,right,left} from the pixel stream
// becomes one CI request. The 2-bit {dy,dx} result of each request is packed
// into a 32-bit word (slot k at bits [2k+1:2k]). A word is handed downstream
// when all 16 slots are full, or when an input marked in_last closes the line.
//
// Ports
//   clock, reset            system clock, asynchronous active-high reset
//   in_valid/in_ready       input handshake
//   in_pixels               [7:0]=left [15:8]=right [23:16]=up [31:24]=down
//   in_last                 last neighbourhood of a line (flushes the word)
//   ci_start                one-cycle start strobe per request
//   ci_n                    CI number (CI_ID while a request is in flight)
//   ci_valueA / ci_valueB   operands: captured pixels / constant 0
//   ci_done / ci_result     completion strobe and result (only [1:0] used)
//   out_valid/out_ready     output handshake
//   out_word                packed results, unused slots 0
//   out_count               number of filled slots (1..16)
//   out_last                word was closed by in_last
//   timeout_err             sticky flag: some request timed out
// -----------------------------------------------------------------------------
module gradient_ci_requester #(
   parameter logic [7:0] CI_ID   = 8'd0,
   parameter int         TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pixels,
   input  logic        in_last,
   output logic        ci_start,
   output logic [7:0]  ci_n,
   output logic [31:0] ci_valueA,
   output logic [31:0] ci_valueB,
   input  logic        ci_done,
   input  logic [31:0] ci_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic [4:0]  out_count,
   output logic        out_last,
   output logic        timeout_err
);

   localparam int             TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

   state_t        state, state_nxt;

   // run holds in_ready low until the first clock edge after reset release,
   // so no input is taken while reset is being released.
   logic          run;
   logic [31:0]   value_a;
   logic          pend_last;
   logic [3:0]    slot;
   logic [4:0]    count;
   logic [31:0]   word;
   logic          word_last;
   logic [TW-1:0] timer;
   logic          err;

   logic          accept;
   logic          finish;
   logic          timed_out;
   logic          handshake;
   logic [1:0]    res_bits;

   logic          unused_result_bits;
   assign unused_result_bits = ^ci_result[31:2];

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and control outputs
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      timed_out = 1'b0;
      handshake = 1'b0;
      res_bits  = 2'b00;
      in_ready  = 1'b0;
      ci_start  = 1'b0;
      ci_n      = 8'd0;
      out_valid = 1'b0;

      case (state)
         IDLE: begin
            in_ready = run;
            if (run && in_valid) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            ci_start = 1'b1;
            ci_n     = CI_ID;
            // A combinational CI may complete in the issue cycle itself.
            if (ci_done) begin
               finish   = 1'b1;
               res_bits = ci_result[1:0];
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            ci_n = CI_ID;
            // done wins over a timeout landing in the same cycle
            if (ci_done) begin
               finish   = 1'b1;
               res_bits = ci_result[1:0];
            end else if (timer == T_LAST) begin
               finish    = 1'b1;
               timed_out = 1'b1;
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               handshake = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (finish) begin
         state_nxt = (slot == 4'd15 || pend_last) ? EMIT : IDLE;
      end
   end

   // Request operand, word packing, timer and error flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run       <= 1'b0;
         value_a   <= '0;
         pend_last <= 1'b0;
         slot      <= '0;
         count     <= '0;
         word      <= '0;
         word_last <= 1'b0;
         timer     <= '0;
         err       <= 1'b0;
      end else begin
         run <= 1'b1;

         if (accept) begin
            value_a   <= in_pixels;
            pend_last <= in_last;
         end

         // Timer restarts on every issue cycle, so it is zero on WAIT entry.
         if (state == ISSUE)     timer <= '0;
         else if (state == WAIT) timer <= timer + 1'b1;

         if (finish) begin
            word[{slot, 1'b0} +: 2] <= res_bits;
            slot                    <= slot + 4'd1;
            count                   <= count + 5'd1;
            word_last               <= pend_last;
         end

         if (timed_out) err <= 1'b1;

         if (handshake) begin
            word      <= '0;
            slot      <= '0;
            count     <= '0;
            word_last <= 1'b0;
         end
      end
   end

   assign ci_valueA   = value_a;
   assign ci_valueB   = 32'd0;
   assign out_word    = word;
   assign out_count   = count;
   assign out_last    = word_last;
   assign timeout_err = err;

endmodule
